// File: rtl/time_of_day_counter.sv
// 24-hour time-of-day counter: prescales the system clock to a 1 s tick and
// keeps hh:mm:ss, with a set mode that freezes time and steps minutes/hours.
module time_of_day_counter #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [5:0] hours,
  output logic       sec_pulse,
  output logic       day_pulse
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [5:0]    sec_nxt;
  logic [5:0]    min_nxt;
  logic [5:0]    hr_nxt;
  logic          tick;
  logic          day_nxt;

  // Modulo increment; anything at or past the limit restarts at zero.
  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] lim);
    return (val >= lim) ? 6'd0 : val + 6'd1;
  endfunction

  // Clears a field that holds an out-of-range value.
  function automatic logic [5:0] sanitize(input logic [5:0] val, input logic [5:0] nxt,
                                          input logic [5:0] lim);
    return (val > lim) ? 6'd0 : nxt;
  endfunction

  always_comb begin
    tick      = !set_en && (presc == PRESC_LAST);
    presc_nxt = (set_en || tick || presc > PRESC_LAST) ? '0 : presc + PW'(1);
    sec_nxt   = seconds;
    min_nxt   = minutes;
    hr_nxt    = hours;
    day_nxt   = 1'b0;
    if (set_en) begin
      sec_nxt = 6'd0;
      if (inc_min)  min_nxt = wrap_inc(minutes, 6'd59);
      if (inc_hour) hr_nxt  = wrap_inc(hours, 6'd23);
    end else if (tick) begin
      // The whole carry chain resolves within this single edge.
      sec_nxt = wrap_inc(seconds, 6'd59);
      if (seconds == 6'd59) begin
        min_nxt = wrap_inc(minutes, 6'd59);
        if (minutes == 6'd59) begin
          hr_nxt  = wrap_inc(hours, 6'd23);
          day_nxt = (hours == 6'd23);
        end
      end
    end
    sec_nxt = sanitize(seconds, sec_nxt, 6'd59);
    min_nxt = sanitize(minutes, min_nxt, 6'd59);
    hr_nxt  = sanitize(hours, hr_nxt, 6'd23);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      seconds   <= 6'd0;
      minutes   <= 6'd0;
      hours     <= 6'd0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      presc     <= presc_nxt;
      seconds   <= sec_nxt;
      minutes   <= min_nxt;
      hours     <= hr_nxt;
      sec_pulse <= tick;
      day_pulse <= day_nxt;
    end
  end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Free-running 24-hour time-of-day counter for the alarm clock. It divides the system clock down to a 1 s tick and counts seconds, minutes and hours. It also provides a set mode for adjusting minutes and hours from debounced buttons. Its 6-bit `hours` output feeds the divide-by-12 stage that produces the AM/PM flag and the 12-hour display value, and its minutes/seconds feed the display and alarm-compare logic.

## Interface
- `CLK_HZ`, default 50_000_000: system clock cycles per second; must be ≥ 2. Simulation uses 4.
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `set_en`  input  1  level; high = set mode (time frozen, adjustable).
- `inc_min`  input  1  single-cycle pulse, already debounced; advance minutes in set mode.
- `inc_hour`  input  1  single-cycle pulse, already debounced; advance hours in set mode.
- `seconds`  output  6  current seconds, 0–59.
- `minutes`  output  6  current minutes, 0–59.
- `hours`  output  6  current hours, 0–23 (6 bits wide, matching the divider numerator).
- `sec_pulse`  output  1  high for one cycle when `seconds` takes a new value in run mode.
- `day_pulse`  output  1  high for one cycle when the time wraps from 23:59:59 to 00:00:00.

## Operation
- Prescaler: a counter of width ceil(log2(CLK_HZ)), range 0..CLK_HZ-1. A second tick is an edge on which the prescaler = CLK_HZ-1. On that edge the prescaler returns to 0.
- Run mode (`set_en`=0), on a second tick:
  - Seconds < 59: seconds+1.
  - Seconds = 59: seconds→0 and minutes advance.
  - Minutes = 59 while advancing: minutes→0 and hours advance.
  - Hours = 23 while advancing: hours→0 and `day_pulse` asserts.
- All carries resolve on the same edge. There is no intermediate 60 or 24 value, ever.
- `inc_min` and `inc_hour` are ignored in run mode.
- Set mode (`set_en`=1):
  - Prescaler is held at 0 and seconds are forced to 0.
  - No second ticks occur, and `sec_pulse` and `day_pulse` stay 0.
  - `inc_min`: minutes+1, wrapping 59→0. There is no carry into hours.
  - `inc_hour`: hours+1, wrapping 23→0.
  - Both pulses in the same cycle: both fields advance independently on that edge.
  - A pulse held for N cycles advances the field N times. Upstream guarantees single-cycle pulses.
- Leaving set mode: the prescaler restarts from 0. The first second tick occurs on the CLK_HZ-th rising edge after the edge that samples `set_en`=0.
- Robustness: any field found above its maximum (unreachable in normal operation) is loaded with 0 on the next edge, regardless of mode.

## Timing
- Reset (async assert, released synchronously by the system): prescaler=0, seconds=0, minutes=0, hours=0, `sec_pulse`=0, `day_pulse`=0. Reset mid-count or mid-set discards all state immediately.
- All outputs are registered. There is no combinational path from any input to any output.
- `sec_pulse` and `day_pulse` are high in the cycle immediately after the tick edge, the same cycle the updated time is first visible.
- Run mode: exactly one second tick per CLK_HZ clock cycles, so `sec_pulse` has a period of exactly CLK_HZ cycles.
- Set-mode increments are visible the cycle after the pulse is sampled: a 1-cycle latency.
- `set_en` rising on the same edge as a would-be tick: set mode wins. Seconds→0, no tick, no pulse.

## Test plan
- Reset, CLK_HZ=4, run 40 cycles → `sec_pulse` on cycles 4, 8, …, 40; seconds reaches 10; minutes=0 and hours=0 throughout.
- Force time to 00:00:58, run mode → after 8 cycles `seconds`=0 and `minutes`=1; the 59→0 transition occurs in one edge, with no 60 value ever observed.
- Force time to 23:59:59 → on the next tick the time is 00:00:00 and `day_pulse` is high for exactly one cycle, coincident with `sec_pulse`.
- Set mode at 10:59:30:
  - `seconds` drops to 0 the next cycle.
  - Pulse `inc_min` once → 10:00:00, hours unchanged.
  - Pulse `inc_hour` 14 times → 00:00:00, wrapping through 23→0.
  - `inc_min` and `inc_hour` in the same cycle → 01:01:00.
- Exit set mode → the first `sec_pulse` occurs exactly 4 cycles later. `inc_min` pulses in run mode leave minutes unchanged.
- Assert `rst` mid-prescale with time at 12:34:56 → all outputs read 0 immediately, with no clock edge required. After release the first `sec_pulse` occurs 4 cycles later.
